button_press_conditioner: RTL and testbench

Conditions a raw, bouncing push-button input into a clean debounced level and a single-cycle press pulse. It is the producer side of the counter's `button` enable input: one press yields exactly one cycle of enable, so the downstream counter advances by exactly 1 per physical press. It contains:
- a 2-flop synchronizer;
- a 4-state debounce FSM;
- an optional auto-repeat timer.

---
 rtl/button_press_conditioner.sv | 137 +++++++++++++
 tb/tb_button_press_conditioner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_conditioner.sv
// button_press_conditioner
// Turns a raw, bouncing push-button into a clean debounced level (btn_level)
// and a one-cycle press pulse (btn_pulse) for a downstream counter enable.
// Structure: 2-flop synchronizer -> 4-state debounce FSM -> registered outputs.
// Optional auto-repeat is compiled in with the macro BUTTON_AUTO_REPEAT_EN;
// without it exactly one pulse is produced per accepted press.

module button_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // All cycle counts must be at least one; reject bad configurations at elaboration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
    $error("button_press_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [CNT_W-1:0] dcnt;
  logic             rpt_fire;

  // Two-flop synchronizer; only s2 is ever looked at by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt;
  logic             rep_phase;
  logic             enter_pressed;

  // The first repeat waits REPEAT_DELAY cycles; later ones wait REPEAT_PERIOD.
  assign rpt_fire      = (rcnt == (rep_phase ? PER_LAST : DLY_LAST));
  assign enter_pressed = ((state == PRESS_DB) && s2 && (dcnt == DB_LAST)) ||
                         ((state == REL_DB) && s2);

  // Repeat timer: restarts on every entry to PRESSED, runs only while PRESSED holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (enter_pressed) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if ((state == PRESSED) && s2) begin
      if (rpt_fire) begin
        rcnt      <= '0;
        rep_phase <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Debounce FSM; btn_level and btn_pulse are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_DB;
            dcnt  <= '0;
          end
        end
        PRESS_DB: begin
          if (!s2) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DB_LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= REL_DB;
            dcnt  <= '0;
          end else if (rpt_fire) begin
            btn_pulse <= 1'b1;
          end
        end
        REL_DB: begin
          if (s2) begin
            state <= PRESSED;
          end else if (dcnt == DB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_conditioner.sv
// Testbench for button_press_conditioner.
// Directed scenarios (clean press, glitch, bouncy press/release, reset mid-press,
// counter integration, auto-repeat window) followed by randomized bounce traffic.
// Every cycle both outputs are compared against a run-length reference model.

module tb_button_press_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int CW = 8;

  logic clk;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic btn_pulse;

  int checks;
  int errors;
  int cycleNo;

  // Reference model state: raw history, run lengths of the synchronized input.
  bit rawHist [2];
  int runOnes;
  int runZeros;
  bit mLevel;
  bit mPulse;
  bit lastSample;
  int heldCycles;

  button_press_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // Level is accepted after DB+1 equal synchronized samples; pulses mark entries
  // into the held state and, with auto-repeat, scheduled repeats while held.
  task automatic modelStep(input bit raw, input bit rst);
    bit sample;
    bit prevLevel;
    bit prevHeld;
    if (rst) begin
      rawHist[0] = 1'b0;
      rawHist[1] = 1'b0;
      runOnes    = 0;
      runZeros   = 0;
      mLevel     = 1'b0;
      mPulse     = 1'b0;
      lastSample = 1'b0;
      heldCycles = 0;
    end else begin
      sample     = rawHist[1];
      rawHist[1] = rawHist[0];
      rawHist[0] = raw;
      if (sample) begin
        runOnes++;
        runZeros = 0;
      end else begin
        runZeros++;
        runOnes = 0;
      end
      prevLevel = mLevel;
      prevHeld  = mLevel && lastSample;
      if (!mLevel && runOnes == DB + 1) mLevel = 1'b1;
      else if (mLevel && runZeros == DB + 1) mLevel = 1'b0;
      mPulse = mLevel && !prevLevel;
`ifdef BUTTON_AUTO_REPEAT_EN
      if (mLevel && sample) begin
        if (prevHeld) begin
          heldCycles++;
          if (heldCycles >= RD && (heldCycles - RD) % RP == 0) mPulse = 1'b1;
        end else begin
          heldCycles = 0;
        end
      end
`else
      if (prevHeld) heldCycles++;
`endif
      lastSample = sample;
    end
  endtask

  task automatic applyStimulus(input bit raw, input bit rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    #1;
    cycleNo++;
    modelStep(raw, rst);
    checkOutput("level", btn_level, mLevel);
    checkOutput("pulse", btn_pulse, mPulse);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // Directed scenarios first, then randomized bounce traffic, then the summary.
  initial begin
    int firstPulse;
    int riseEdge;
    int fallEdge;
    int pulses;
    int levelHigh;
    int levelChanges;
    bit prevLvl;
    logic [3:0] counter;
    bit bounceIn [6];
    bit bounceOut [3];
    int expClean;
    int expBouncy;
    int expRepeat;
    int total;
    bit curVal;
    int segLen;

    checks  = 0;
    errors  = 0;
    cycleNo = 0;
    btn_raw = 1'b0;
    reset   = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
    expClean  = 3;
    expBouncy = 2;
    expRepeat = 7;
`else
    expClean  = 1;
    expBouncy = 1;
    expRepeat = 1;
`endif

    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_level", btn_level, 0);
    checkOutput("reset_pulse", btn_pulse, 0);
    idleCycles(10);

    // Clean press: 20 cycles high, then release.
    firstPulse = -1; riseEdge = -1; fallEdge = -1; pulses = 0;
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (btn_pulse === 1'b1) begin
        pulses++;
        if (firstPulse < 0) firstPulse = e;
      end
      if (btn_level === 1'b1 && riseEdge < 0) riseEdge = e;
    end
    for (int e = 0; e < 12; e++) begin
      applyStimulus(1'b0, 1'b0);
      if (btn_pulse === 1'b1) pulses++;
      if (btn_level === 1'b0 && fallEdge < 0) fallEdge = e;
    end
    checkOutput("clean_pulse_edge", firstPulse, DB + 2);
    checkOutput("clean_rise_edge", riseEdge, DB + 2);
    checkOutput("clean_fall_edge", fallEdge, DB + 2);
    checkOutput("clean_pulse_count", pulses, expClean);

    // Glitch: 3 cycles high is too short to be accepted.
    pulses = 0; levelHigh = 0;
    for (int e = 0; e < 15; e++) begin
      applyStimulus(e < 3, 1'b0);
      if (btn_pulse === 1'b1) pulses++;
      if (btn_level === 1'b1) levelHigh++;
    end
    checkOutput("glitch_pulses", pulses, 0);
    checkOutput("glitch_level", levelHigh, 0);

    // Bouncy press and release: one rise, one fall, release bounce ignored.
    bounceIn  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bounceOut = '{1'b0, 1'b1, 1'b0};
    pulses = 0; levelChanges = 0; prevLvl = 1'b0; fallEdge = -1;
    for (int e = 0; e < 36; e++) begin
      if (e < 6) applyStimulus(bounceIn[e], 1'b0);
      else if (e < 21) applyStimulus(1'b1, 1'b0);
      else if (e < 24) applyStimulus(bounceOut[e-21], 1'b0);
      else applyStimulus(1'b0, 1'b0);
      if (btn_pulse === 1'b1) pulses++;
      if (btn_level !== prevLvl) levelChanges++;
      if (prevLvl == 1'b1 && btn_level === 1'b0) fallEdge = e;
      prevLvl = btn_level;
    end
    checkOutput("bouncy_pulses", pulses, expBouncy);
    checkOutput("bouncy_level_changes", levelChanges, 2);
    checkOutput("bouncy_fall_edge", fallEdge, 29);

    // Reset while held: outputs cleared, press re-detected after reset.
    for (int e = 0; e < 12; e++) applyStimulus(1'b1, 1'b0);
    checkOutput("held_level_before_reset", btn_level, 1);
    for (int e = 0; e < 2; e++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("midreset_level", btn_level, 0);
      checkOutput("midreset_pulse", btn_pulse, 0);
    end
    firstPulse = -1; pulses = 0;
    for (int e = 0; e < 10; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (btn_pulse === 1'b1) begin
        pulses++;
        if (firstPulse < 0) firstPulse = e;
      end
    end
    checkOutput("after_reset_pulse_edge", firstPulse, DB + 2);
    checkOutput("after_reset_pulse_count", pulses, 1);
    idleCycles(12);

    // Counter integration: five clean presses advance a 4-bit counter to 5.
    counter = 4'd0;
    for (int p = 0; p < 5; p++) begin
      for (int e = 0; e < 18; e++) begin
        applyStimulus(e < 8, 1'b0);
        if (btn_pulse === 1'b1) counter = counter + 4'd1;
      end
    end
    checkOutput("counter_value", counter, 4'd5);

    // Long hold: pulses in the window from the press pulse through the fifth period.
    pulses = 0; firstPulse = -1;
    for (int e = 0; e < 40; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (btn_pulse === 1'b1) begin
        if (firstPulse < 0) firstPulse = e;
        if (e >= DB + 2 && e <= DB + 2 + RD + 5 * RP) pulses++;
      end
    end
    checkOutput("hold_first_pulse", firstPulse, DB + 2);
    checkOutput("hold_window_pulses", pulses, expRepeat);
    idleCycles(12);

    // Randomized bouncing with occasional resets, checked cycle by cycle.
    total  = 0;
    curVal = 1'b0;
    while (total < 2500) begin
      if ($urandom_range(0, 19) == 0) begin
        segLen = $urandom_range(1, 3);
        for (int i = 0; i < segLen; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        curVal = ~curVal;
        segLen = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
        for (int i = 0; i < segLen; i++) applyStimulus(curVal, 1'b0);
      end
      total += segLen;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
